// File: rtl/rv_pkg.sv
// Shared constants and types for the instruction fetch path.
// Holds the FIFO occupancy states and the {pc, inst} entry layout.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue of {pc, inst}; slot 0 is always the head.
// Flush wins over push and pop; simultaneous push and pop keeps the occupancy.
module fetch_fifo
  import rv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);

  fifo_state_e  state, state_next;
  fetch_entry_t slot [2];
  logic         pop_ok, push_ok, wr_idx;

  assign pop_ok  = pop && (state != FIFO_EMPTY);
  assign push_ok = push && ((state != FIFO_FULL) || pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FIFO_EMPTY;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default first so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FIFO_EMPTY;
    end else begin
      unique case (state)
        FIFO_EMPTY: if (push_ok) state_next = FIFO_ONE;
        FIFO_ONE: begin
          if (push_ok && !pop_ok)      state_next = FIFO_FULL;
          else if (pop_ok && !push_ok) state_next = FIFO_EMPTY;
        end
        FIFO_FULL: if (pop_ok && !push_ok) state_next = FIFO_ONE;
        default:   state_next = FIFO_EMPTY;
      endcase
    end
  end

  // New entry lands behind whatever survives this edge's pop.
  assign wr_idx = (state == FIFO_FULL) || ((state == FIFO_ONE) && !pop_ok);

  // NOTE: the data slots carry no reset; head_valid from the state register masks stale contents.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pop_ok && (state == FIFO_FULL)) slot[0] <= slot[1];
      if (push_ok)                        slot[wr_idx] <= wr_entry;
    end
  end

  assign count      = state;
  assign head_valid = (state != FIFO_EMPTY);
  assign head       = slot[0];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a 2-deep decoupling queue toward decode.
// Redirects flush the queue and reload the PC; misaligned targets set a sticky flag.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] im_addr,
  input  logic [XLEN-1:0] im_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic            misalign_err
);

  logic [XLEN-1:0] pc;
  logic [1:0]      count;
  logic            head_valid;
  fetch_entry_t    head;
  logic            pop, push;

  assign im_addr = pc;
  assign pop     = out_valid && out_ready;
  assign push    = !redirect_valid && ((count < 2'd2) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (push) begin
      pc <= pc + INST_BYTES;
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .wr_entry   ('{pc: pc, inst: im_inst}),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  // An empty queue presents a NOP at PC 0 so decode never sees stale data.
  assign out_valid = head_valid;
  assign out_inst  = head_valid ? head.inst : NOP_INST;
  assign out_pc    = head_valid ? head.pc : '0;
  assign out_pc4   = head_valid ? head.pc + INST_BYTES : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-level model predicts each accepted
// instruction; a negedge monitor compares whenever decode accepts the head.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] im_addr, im_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_pc4;
  logic        misalign_err;

  int n_pass = 0;
  int n_total = 0;

  ent_t        mq[$];
  ent_t        sb[$];
  ent_t        mon_e;
  logic [31:0] mpc = RESET_PC;
  logic        merr = 1'b0;
  logic        now_valid = 1'b0;
  logic [31:0] now_pc = RESET_PC;
  logic        now_err = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h0010_0093;
      30'd1:   return 32'h0060_0113;
      30'd37:  return 32'h0080_00EF;
      30'd38:  return 32'hDEAD_BEEF;
      30'd39:  return 32'h0140_0293;
      default: return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign im_inst = mem_word(im_addr);

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .im_addr        (im_addr),
    .im_inst        (im_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .misalign_err   (misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Called between edges: drives inputs for the next edge and advances the model over it.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc);
    ent_t e;
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    now_valid = (mq.size() != 0);
    now_pc    = mpc;
    now_err   = merr;
    if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) merr = 1'b1;
    end else begin
      if (mq.size() != 0 && r) begin
        e = mq.pop_front();
        sb.push_back(e);
      end
      if (mq.size() < 2) begin
        e.pc   = mpc;
        e.inst = mem_word(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Entered just after a rising edge; asserts reset between edges and releases it after the next one.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    mq.delete();
    sb.delete();
    mpc = RESET_PC;
    merr = 1'b0;
    now_valid = 1'b0;
    now_pc = RESET_PC;
    now_err = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_im_addr", im_addr, RESET_PC);
    check("rst_out_inst", out_inst, NOP);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_pc4", out_pc4, 0);
    check("rst_misalign", misalign_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("mon_valid", out_valid, now_valid);
      check("mon_im_addr", im_addr, now_pc);
      check("mon_misalign", misalign_err, now_err);
      if (out_valid && out_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got pc 0x%08h, expected no accept at %0t", out_pc, $time);
        end else begin
          mon_e = sb.pop_front();
          check("mon_inst", out_inst, mon_e.inst);
          check("mon_pc", out_pc, mon_e.pc);
          check("mon_pc4", out_pc4, mon_e.pc + 32'd4);
        end
      end else if (!out_valid) begin
        check("idle_inst", out_inst, NOP);
        check("idle_pc", out_pc, 0);
        check("idle_pc4", out_pc4, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rpc;
    logic        r, rv;

    do_reset();

    // First fetch right after release, then streaming.
    cycle(1, 0, 0);
    check("t37_pc0", out_pc, 32'h0);
    check("t37_inst0", out_inst, 32'h0010_0093);
    check("t37_pc4", out_pc4, 32'h4);
    cycle(1, 0, 0);
    check("t37_pc1", out_pc, 32'h4);
    check("t37_inst1", out_inst, 32'h0060_0113);

    // Back-pressure saturates the queue, then drains one per cycle.
    do_reset();
    repeat (4) cycle(0, 0, 0);
    check("t38_im_addr", im_addr, 32'h8);
    check("t38_head", out_pc, 32'h0);
    cycle(1, 0, 0);
    check("t38_head1", out_pc, 32'h4);
    cycle(1, 0, 0);
    check("t38_head2", out_pc, 32'h8);

    // Redirect while full.
    cycle(0, 1, 32'h94);
    check("t39_valid", out_valid, 0);
    check("t39_inst_nop", out_inst, NOP);
    check("t39_im_addr", im_addr, 32'h94);
    cycle(0, 0, 0);
    check("t39_inst", out_inst, 32'h0080_00EF);
    check("t39_pc", out_pc, 32'h94);

    // Misaligned redirect: aligned fetch, sticky flag.
    cycle(1, 1, 32'h9E);
    check("t40_im_addr", im_addr, 32'h9C);
    check("t40_err", misalign_err, 1);
    cycle(1, 0, 0);
    check("t40_inst", out_inst, 32'h0140_0293);
    repeat (3) cycle(1, 0, 0);
    check("t40_err_sticky", misalign_err, 1);
    do_reset();

    // PC wrap at the top of the address space.
    cycle(1, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    check("t41_pc", out_pc, 32'hFFFF_FFFC);
    check("t41_pc4", out_pc4, 32'h0);
    cycle(1, 0, 0);
    check("t41_pc_wrap", out_pc, 32'h0);
    check("t41_err", misalign_err, 0);

    // Asynchronous reset while full.
    repeat (3) cycle(0, 0, 0);
    check("t42_full_valid", out_valid, 1);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
      else                           rpc = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle(r, rv, rpc);
    end
    cycle(1, 0, 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
